// File: rtl/ray_frame_scheduler_pkg.sv
// Shared types for the frame scheduler: camera bundle, FSM states
// and default raster / credit sizing.
package ray_frame_scheduler_pkg;

    typedef struct packed {
        logic signed [15:0] pos_x;
        logic signed [15:0] pos_y;
        logic signed [15:0] pos_z;
        logic signed [15:0] dir_x;
        logic signed [15:0] dir_y;
        logic signed [15:0] dir_z;
        logic        [15:0] fov;
    } Camera;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

    localparam int H_RES_DEF        = 640;
    localparam int V_RES_DEF        = 480;
    localparam int PIXEL_WIDTH_DEF  = 10;
    localparam int PIXEL_HEIGHT_DEF = 9;
    localparam int TAG_SIZE         = 48;
    localparam int TAG_BITS_DEF     = 6;

endpackage

// File: rtl/ray_frame_scheduler_raster_counter.sv
// Raster-order x/y walker with wrap-around and last-pixel flag,
// advanced once per accepted pixel.
module raster_counter #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int PIXEL_WIDTH  = 10,
    parameter int PIXEL_HEIGHT = 9
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    advance,
    output logic [PIXEL_WIDTH-1:0]  x,
    output logic [PIXEL_HEIGHT-1:0] y,
    output logic                    last
);

    localparam logic [PIXEL_WIDTH-1:0]  X_MAX = PIXEL_WIDTH'(H_RES - 1);
    localparam logic [PIXEL_HEIGHT-1:0] Y_MAX = PIXEL_HEIGHT'(V_RES - 1);

    logic x_end;
    logic y_end;

    assign x_end = (x == X_MAX);
    assign y_end = (y == Y_MAX);
    assign last  = x_end && y_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + PIXEL_HEIGHT'(1);
            end else begin
                x <= x + PIXEL_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/ray_frame_scheduler.sv
// Frame scheduler: latches the camera, issues tagged pixels in raster
// order under a credit limit, and drains returns before reporting done.
module ray_frame_scheduler
    import ray_frame_scheduler_pkg::*;
#(
    parameter int H_RES        = H_RES_DEF,
    parameter int V_RES        = V_RES_DEF,
    parameter int PIXEL_WIDTH  = PIXEL_WIDTH_DEF,
    parameter int PIXEL_HEIGHT = PIXEL_HEIGHT_DEF,
    parameter int MAX_INFLIGHT = TAG_SIZE,
    parameter int TAG_BITS     = TAG_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  Camera                   cam_in,
    output Camera                   cam_out,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [PIXEL_WIDTH-1:0]  pixel_x,
    output logic [PIXEL_HEIGHT-1:0] pixel_y,
    output logic [TAG_BITS-1:0]     tag_out,
    input  logic                    ret_valid,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    aborted,
    output logic                    ret_err
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0]       CREDITS = CW'(MAX_INFLIGHT);
    localparam logic [TAG_BITS-1:0] TAG_MAX = TAG_BITS'(MAX_INFLIGHT - 1);

    sched_state_t  state;
    sched_state_t  state_nxt;
    logic [CW-1:0] inflight;
    logic          launch;
    logic          fire;
    logic          last_pix;
    logic          ret_bad;
    logic          drain_empty;

    assign launch    = (state == IDLE) && start;
    assign pix_valid = (state == RUN) && (inflight < CREDITS);
    assign fire      = pix_valid && pix_ready;
    assign ret_bad   = ret_valid && !fire && (inflight == '0);
    // A return landing this cycle may be the one that empties the pipe.
    assign drain_empty = (inflight == '0) ||
                         ((inflight == CW'(1)) && ret_valid);

    assign busy       = (state == RUN) || (state == DRAIN);
    assign frame_done = (state == DONE);

    raster_counter #(
        .H_RES        (H_RES),
        .V_RES        (V_RES),
        .PIXEL_WIDTH  (PIXEL_WIDTH),
        .PIXEL_HEIGHT (PIXEL_HEIGHT)
    ) u_raster (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (launch),
        .advance (fire),
        .x       (pixel_x),
        .y       (pixel_y),
        .last    (last_pix)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort || (fire && last_pix)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_empty) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Simultaneous issue and return cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
        end else if (fire && !ret_valid) begin
            inflight <= inflight + CW'(1);
        end else if (!fire && ret_valid && (inflight != '0)) begin
            inflight <= inflight - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_out <= '0;
        end else if (launch) begin
            tag_out <= '0;
        end else if (fire) begin
            tag_out <= (tag_out == TAG_MAX) ? '0 : tag_out + TAG_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cam_out <= '0;
        end else if (launch) begin
            cam_out <= cam_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aborted <= 1'b0;
        end else if (launch) begin
            aborted <= 1'b0;
        end else if ((state == RUN) && abort) begin
            aborted <= 1'b1;
        end
    end

    // A spurious return in the start cycle is still recorded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ret_err <= 1'b0;
        end else if (ret_bad) begin
            ret_err <= 1'b1;
        end else if (launch) begin
            ret_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ray_frame_scheduler.sv
// Directed bench for ray_frame_scheduler on a 4x3 raster with 4 credits.
module tb_ray_frame_scheduler;
    import ray_frame_scheduler_pkg::*;

    localparam Camera CAM_A = 112'h0001_0002_0003_0004_0005_0006_0007;
    localparam Camera CAM_B = 112'hA0A0_B1B1_C2C2_D3D3_E4E4_F5F5_0660;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    Camera       cam_in;
    Camera       cam_out;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic [5:0]  tag_out;
    logic        ret_valid;
    logic        busy;
    logic        frame_done;
    logic        aborted;
    logic        ret_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ray_frame_scheduler #(
        .H_RES        (4),
        .V_RES        (3),
        .PIXEL_WIDTH  (10),
        .PIXEL_HEIGHT (9),
        .MAX_INFLIGHT (4),
        .TAG_BITS     (6)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .cam_in     (cam_in),
        .cam_out    (cam_out),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .tag_out    (tag_out),
        .ret_valid  (ret_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .aborted    (aborted),
        .ret_err    (ret_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic rdy, input logic ret, input logic abt);
        pix_ready = rdy;
        ret_valid = ret;
        abort     = abt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        pix_ready = 1'b0;
        ret_valid = 1'b0;
        cam_in    = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_frame(input Camera cam);
        cam_in    = cam;
        pix_ready = 1'b0;
        ret_valid = 1'b0;
        abort     = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({pix_valid, busy, frame_done, aborted, ret_err} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000",
                     {pix_valid, busy, frame_done, aborted, ret_err});
        else pass_cnt++;
        total_cnt++;
        if ({pixel_x, pixel_y, tag_out} !== 25'b0)
            $display("FAIL reset_coords: got x=%0d y=%0d tag=%0d want 0 0 0",
                     pixel_x, pixel_y, tag_out);
        else pass_cnt++;
        total_cnt++;
        if (cam_out !== Camera'(0))
            $display("FAIL reset_cam: got %h want 0", cam_out);
        else pass_cnt++;
    endtask

    task automatic test_full_frame();
        bit   rs [0:255];
        int   fires = 0;
        int   rets  = 0;
        int   inf   = 0;
        int   dn    = 0;
        int   dcyc  = -1;
        int   lcyc  = -10;
        int   vbad  = 0;
        logic f;
        logic r;
        logic ev;
        do_reset();
        start_frame(CAM_A);
        total_cnt++;
        if (pix_valid !== 1'b1)
            $display("FAIL start_latency: got pix_valid=%b want 1", pix_valid);
        else pass_cnt++;
        for (int c = 0; c < 120; c++) begin
            ev = (fires < 12) && (inf < 4);
            if (pix_valid !== ev) vbad++;
            if (frame_done === 1'b1) begin
                dn++;
                dcyc = c;
            end
            f = (pix_valid === 1'b1);
            if (f) begin
                total_cnt++;
                if ({pixel_x, pixel_y, tag_out} !==
                    {10'(fires % 4), 9'(fires / 4), 6'(fires % 4)})
                    $display("FAIL frame_pixel%0d: got x=%0d y=%0d tag=%0d want x=%0d y=%0d tag=%0d",
                             fires, pixel_x, pixel_y, tag_out,
                             fires % 4, fires / 4, fires % 4);
                else pass_cnt++;
                rs[c + 5] = 1'b1;
                fires++;
            end
            r = rs[c];
            if (r) begin
                rets++;
                lcyc = c;
            end
            inf = inf + int'(f) - int'(r);
            step(1'b1, r, 1'b0);
        end
        total_cnt++;
        if (fires != 12)
            $display("FAIL frame_fires: got %0d want 12", fires);
        else pass_cnt++;
        total_cnt++;
        if (vbad != 0)
            $display("FAIL frame_credit_stall: got %0d bad pix_valid cycles want 0", vbad);
        else pass_cnt++;
        total_cnt++;
        if (dn != 1)
            $display("FAIL frame_done_count: got %0d want 1", dn);
        else pass_cnt++;
        total_cnt++;
        if (dcyc != lcyc + 1)
            $display("FAIL frame_done_time: got cycle %0d want %0d", dcyc, lcyc + 1);
        else pass_cnt++;
        total_cnt++;
        if ({busy, aborted} !== 2'b00)
            $display("FAIL frame_idle_after: got busy=%b aborted=%b want 0 0", busy, aborted);
        else pass_cnt++;
    endtask

    task automatic test_credit_limit();
        int fires = 0;
        logic [24:0] seen = '0;
        do_reset();
        start_frame(CAM_A);
        for (int c = 0; c < 20; c++) begin
            if (pix_valid === 1'b1) fires++;
            step(1'b1, 1'b0, 1'b0);
        end
        total_cnt++;
        if (fires != 4)
            $display("FAIL credit_fires: got %0d want 4", fires);
        else pass_cnt++;
        total_cnt++;
        if ({pix_valid, busy} !== 2'b01)
            $display("FAIL credit_stalled: got valid=%b busy=%b want 0 1", pix_valid, busy);
        else pass_cnt++;
        step(1'b1, 1'b1, 1'b0);
        fires = 0;
        for (int c = 0; c < 10; c++) begin
            if (pix_valid === 1'b1) begin
                fires++;
                seen = {pixel_x, pixel_y, tag_out};
            end
            step(1'b1, 1'b0, 1'b0);
        end
        total_cnt++;
        if (fires != 1)
            $display("FAIL credit_refill_fires: got %0d want 1", fires);
        else pass_cnt++;
        total_cnt++;
        if (seen !== {10'd0, 9'd1, 6'd0})
            $display("FAIL credit_refill_pixel: got %h want %h", seen, {10'd0, 9'd1, 6'd0});
        else pass_cnt++;
    endtask

    task automatic test_ready_toggle();
        logic rdy [0:7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int k = 0;
        do_reset();
        start_frame(CAM_A);
        for (int c = 0; c < 8; c++) begin
            total_cnt++;
            if ({pix_valid, pixel_x, pixel_y, tag_out} !==
                {1'b1, 10'(k % 4), 9'(k / 4), 6'(k % 4)})
                $display("FAIL toggle_c%0d: got v=%b x=%0d y=%0d tag=%0d want v=1 x=%0d y=%0d tag=%0d",
                         c, pix_valid, pixel_x, pixel_y, tag_out, k % 4, k / 4, k % 4);
            else pass_cnt++;
            if (rdy[c]) k++;
            step(rdy[c], 1'b0, 1'b0);
        end
        total_cnt++;
        if ({pix_valid, pixel_x, pixel_y, tag_out} !== {1'b0, 10'd0, 9'd1, 6'd0})
            $display("FAIL toggle_end: got v=%b x=%0d y=%0d tag=%0d want v=0 x=0 y=1 tag=0",
                     pix_valid, pixel_x, pixel_y, tag_out);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        do_reset();
        start_frame(CAM_A);
        repeat (4) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        total_cnt++;
        if ({pix_valid, pixel_x, pixel_y, tag_out} !== {1'b1, 10'd1, 9'd1, 6'd1})
            $display("FAIL abort_pre: got v=%b x=%0d y=%0d tag=%0d want v=1 x=1 y=1 tag=1",
                     pix_valid, pixel_x, pixel_y, tag_out);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b1);
        total_cnt++;
        if ({pix_valid, busy, aborted, frame_done} !== 4'b0110)
            $display("FAIL abort_drain: got v=%b busy=%b ab=%b done=%b want 0 1 1 0",
                     pix_valid, busy, aborted, frame_done);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b0);
            total_cnt++;
            if ({pix_valid, busy, frame_done} !== 3'b010)
                $display("FAIL abort_ret%0d: got v=%b busy=%b done=%b want 0 1 0",
                         i, pix_valid, busy, frame_done);
            else pass_cnt++;
        end
        step(1'b0, 1'b1, 1'b0);
        total_cnt++;
        if ({frame_done, busy, aborted} !== 3'b101)
            $display("FAIL abort_done: got done=%b busy=%b ab=%b want 1 0 1",
                     frame_done, busy, aborted);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b0);
        total_cnt++;
        if ({frame_done, busy, aborted} !== 3'b001)
            $display("FAIL abort_after: got done=%b busy=%b ab=%b want 0 0 1",
                     frame_done, busy, aborted);
        else pass_cnt++;
    endtask

    task automatic test_cam_and_ret_err();
        int fires = 0;
        do_reset();
        start_frame(CAM_A);
        cam_in = CAM_B;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            if (pix_valid === 1'b1) fires++;
            step(1'b1, 1'b0, 1'b0);
        end
        total_cnt++;
        if (fires != 3)
            $display("FAIL same_cycle_credit: got %0d more fires want 3", fires);
        else pass_cnt++;
        total_cnt++;
        if ({pixel_x, pixel_y, tag_out} !== {10'd1, 9'd1, 6'd1})
            $display("FAIL same_cycle_pixel: got x=%0d y=%0d tag=%0d want 1 1 1",
                     pixel_x, pixel_y, tag_out);
        else pass_cnt++;
        total_cnt++;
        if (cam_out !== CAM_A)
            $display("FAIL cam_hold: got %h want %h", cam_out, CAM_A);
        else pass_cnt++;
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        total_cnt++;
        if ({ret_err, busy} !== 2'b10)
            $display("FAIL ret_err_idle: got err=%b busy=%b want 1 0", ret_err, busy);
        else pass_cnt++;
        start_frame(CAM_B);
        total_cnt++;
        if ({ret_err, busy} !== 2'b01)
            $display("FAIL ret_err_clear: got err=%b busy=%b want 0 1", ret_err, busy);
        else pass_cnt++;
        total_cnt++;
        if (cam_out !== CAM_B)
            $display("FAIL cam_latch: got %h want %h", cam_out, CAM_B);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        start_frame(CAM_A);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        total_cnt++;
        if ({busy, pixel_x, tag_out} !== {1'b1, 10'd3, 6'd3})
            $display("FAIL midrun_pre: got busy=%b x=%0d tag=%0d want 1 3 3",
                     busy, pixel_x, tag_out);
        else pass_cnt++;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({pix_valid, busy, pixel_x, pixel_y, tag_out} !== 27'b0 || cam_out !== Camera'(0))
            $display("FAIL midrun_reset: got v=%b busy=%b x=%0d y=%0d tag=%0d cam=%h want all 0",
                     pix_valid, busy, pixel_x, pixel_y, tag_out, cam_out);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (ret_err !== 1'b1)
            $display("FAIL midrun_late_ret: got err=%b want 1", ret_err);
        else pass_cnt++;
        start_frame(CAM_B);
        total_cnt++;
        if ({pix_valid, pixel_x, pixel_y, tag_out, ret_err} !== {1'b1, 26'b0})
            $display("FAIL midrun_restart: got v=%b x=%0d y=%0d tag=%0d err=%b want 1 0 0 0 0",
                     pix_valid, pixel_x, pixel_y, tag_out, ret_err);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_credit_limit();
        test_ready_toggle();
        test_abort();
        test_cam_and_ret_err();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ray_frame_scheduler.md
Name: ray_frame_scheduler

Overview:
Frame-level controller that sequences pixel issue into the ray generation datapath. For each frame it latches the camera once and walks pixel coordinates in raster order. Each issued pixel gets a tag, and the scheduler issues over a valid/ready handshake. It bounds in-flight rays with a credit counter so the tagged normalization pipeline never holds more than MAX_INFLIGHT rays. It reports frame completion only after every issued ray has returned.

Parameters:
H_RES, 640, horizontal pixels per line.
V_RES, 480, lines per frame.
PIXEL_WIDTH, 10, width of pixel_x (must satisfy 2^PIXEL_WIDTH >= H_RES).
PIXEL_HEIGHT, 9, width of pixel_y (must satisfy 2^PIXEL_HEIGHT >= V_RES).
MAX_INFLIGHT, 48, maximum outstanding rays; equals the normalization TAG_SIZE.
TAG_BITS, 6, width of tag_out (must satisfy 2^TAG_BITS >= MAX_INFLIGHT).

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  level; begin a frame when sampled in IDLE
abort  input  1  stop issuing; drain outstanding rays, then finish
cam_in  input  Camera  live camera from host
cam_out  output  Camera  camera latched at frame start; stable for the whole frame
pix_valid  output  1  pixel/tag available
pix_ready  input  1  datapath accepts the pixel
pixel_x  output  PIXEL_WIDTH  current column
pixel_y  output  PIXEL_HEIGHT  current row
tag_out  output  TAG_BITS  tag for the current pixel
ret_valid  input  1  one ray completed (one pulse per ray)
busy  output  1  high in RUN or DRAIN
frame_done  output  1  one-cycle pulse at end of frame
aborted  output  1  frame ended by abort; held until next start
ret_err  output  1  sticky: ret_valid seen with inflight==0; cleared on start

Behaviour:
- Reset (async assert, sync deassert): state=IDLE. pixel_x=0, pixel_y=0, tag_out=0, inflight=0, cam_out=0. pix_valid=0, busy=0, frame_done=0, aborted=0, ret_err=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when start=1. On that edge: cam_out<=cam_in, x=y=tag=0, aborted<=0, ret_err<=0. The inflight count is not cleared, because IDLE implies it is already 0.
- Latency: start sampled at edge N gives pix_valid=1 at the earliest in the cycle after edge N.
- RUN: pix_valid = (inflight < MAX_INFLIGHT). pix_valid never depends on pix_ready.
- While pix_valid=1 and pix_ready=0, pixel_x, pixel_y and tag_out hold stable.
- fire = pix_valid & pix_ready. On fire:
  - pixel_x advances; at H_RES-1 it wraps to 0 and pixel_y advances.
  - tag_out advances and wraps MAX_INFLIGHT-1 -> 0.
  - inflight increments.
- Firing pixel (H_RES-1, V_RES-1) -> DRAIN. Coordinates return to (0,0) and pix_valid drops the next cycle.
- abort=1 in RUN -> DRAIN next cycle and sets aborted. A fire in that same cycle still completes and is counted.
- abort in IDLE, DRAIN or DONE is ignored.
- inflight update: fire alone +1, ret_valid alone -1, both together unchanged.
- ret_valid with inflight==0 (and no same-cycle fire): count stays 0 and ret_err is set.
- inflight is legal only in 0..MAX_INFLIGHT; fire at MAX_INFLIGHT is impossible because pix_valid=0 there.
- DRAIN: pix_valid=0. Go to DONE when inflight==0, including when a ret_valid takes it to 0 in this cycle.
- DONE: frame_done=1 for exactly one cycle, busy=0, then IDLE.
- A start held high after DONE begins the next frame from IDLE, so frames are at least 2 cycles apart.
- cam_in changes during RUN or DRAIN do not affect cam_out.
- Asserting reset_n low mid-frame: all state clears immediately. Returns from the datapath that arrive after reset are treated as errors (ret_err).
- busy = (state==RUN || state==DRAIN).

Decomposition:
- Shared package (Types.sv): Camera typedef (existing); a sched_state_t enum {IDLE, RUN, DRAIN, DONE}; H_RES/V_RES defaults alongside PIXEL_WIDTH/PIXEL_HEIGHT/TAG_SIZE macros.
- One natural sub-module: raster_counter. It holds x/y with wrap-around and a last-pixel flag, advanced by fire.
- The credit counter and FSM stay in the top module.

Test Plan:
- H_RES=4, V_RES=3, MAX_INFLIGHT=4, pix_ready=1, ret_valid 5 cycles after each fire -> 12 fires in order (0,0)..(3,2). Tags 0,1,2,3,0,..; pix_valid stalls whenever inflight reaches 4; frame_done pulses once, 1 cycle after the 12th return.
- Same config, no returns -> exactly 4 fires then pix_valid=0 indefinitely. Then one ret_valid -> exactly one more fire, carrying tag 0 and pixel (0,1).
- pix_ready toggled 1,0,0,1 -> pixel_x, pixel_y and tag_out stable across the 0 cycles; no pixel skipped or duplicated.
- abort asserted after 5 fires with 2 returns -> pix_valid drops next cycle; DRAIN lasts until 3 more returns; then frame_done and aborted=1.
- cam_in changed mid-frame and fire+ret_valid applied in the same cycle -> cam_out unchanged and inflight unchanged. Also ret_valid in IDLE -> ret_err=1, cleared by the next start.
- reset_n pulled low mid-RUN with inflight=3 -> outputs at reset values immediately; the next start begins at (0,0), tag 0.
